// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the data-RAM arbiter.
// Optional feature macro used by the arbiter: RAM_ARB_DBG_WRITE_EN.
package ram_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
    typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

    localparam int RAM_ADDR_W = 10;
    localparam int RAM_DATA_W = 32;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational two-way round-robin pick between the CPU and debug requesters.
// On a tie the requester that did not own the last completed transaction wins.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dbg_req,
    input  logic last_own,
    output logic grant,
    output logic owner
);

    always_comb begin
        grant = cpu_req | dbg_req;
        if (cpu_req && dbg_req)
            owner = (last_own == OWN_CPU) ? OWN_DBG : OWN_CPU;
        else if (dbg_req)
            owner = OWN_DBG;
        else
            owner = OWN_CPU;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the MIC1 port and
// the debug port. Define RAM_ARB_DBG_WRITE_EN to let the debug port write.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    arb_state_t        state;
    owner_t            owner, last_own;
    logic              we_l;
    logic [1:0]        cnt;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
    logic              pick_gnt, pick_own;
    logic              dbg_wr;
    logic [DATA_W-1:0] dbg_wdata_eff;

`ifdef RAM_ARB_DBG_WRITE_EN
    assign dbg_wr        = dbg_we;
    assign dbg_wdata_eff = dbg_wdata;
`else
    logic unused_dbg;
    assign dbg_wr        = 1'b0;
    assign dbg_wdata_eff = ram_data;
    assign unused_dbg    = ^{dbg_we, dbg_wdata};
`endif

    ram_arb_pick u_pick (
        .cpu_req  (cpu_req),
        .dbg_req  (dbg_req),
        .last_own (last_own),
        .grant    (pick_gnt),
        .owner    (pick_own)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= OWN_CPU;
            last_own    <= OWN_DBG;
            we_l        <= 1'b0;
            cnt         <= '0;
            ram_addr    <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            cpu_ack     <= 1'b0;
            dbg_ack     <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            cpu_ack  <= 1'b0;
            dbg_ack  <= 1'b0;
            ram_wren <= 1'b0;
            case (state)
                IDLE: if (pick_gnt) begin
                    owner <= owner_t'(pick_own);
                    state <= ISSUE;
                    if (pick_own == OWN_DBG) begin
                        we_l     <= dbg_wr;
                        ram_wren <= dbg_wr;
                        ram_addr <= dbg_addr;
                        ram_data <= dbg_wdata_eff;
                    end else begin
                        we_l     <= cpu_we;
                        ram_wren <= cpu_we;
                        ram_addr <= cpu_addr;
                        ram_data <= cpu_wdata;
                    end
                end
                ISSUE: if (we_l || RD_LAT == 1) begin
                    state   <= DONE;
                    cpu_ack <= (owner == OWN_CPU);
                    dbg_ack <= (owner == OWN_DBG);
                end else begin
                    cnt   <= 2'(RD_LAT - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state   <= DONE;
                        cpu_ack <= (owner == OWN_CPU);
                        dbg_ack <= (owner == OWN_DBG);
                    end
                end
                DONE: begin
                    last_own <= owner;
                    state    <= IDLE;
                    if (!we_l) begin
                        if (owner == OWN_CPU) cpu_rdata_q <= ram_q;
                        else                  dbg_rdata_q <= ram_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data passes straight through during the ack cycle, then the register holds it.
    assign cpu_rdata = (cpu_ack && !we_l) ? ram_q : cpu_rdata_q;
    assign dbg_rdata = (dbg_ack && !we_l) ? ram_q : dbg_rdata_q;
    assign busy      = (state != IDLE);

endmodule
